// File: rtl/nic8_pkg.sv
// Shared definitions for the nic8 datapath: default width, sequencer state
// encoding and opcode field helpers used by the fetch unit and decoder.
package nic8_pkg;

  localparam int NIC8_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } fetchState_t;

  // Opcode layout: bit7 | dest[6:4] | bit3 | source[2:0]
  localparam int OP_BIT7     = 7;
  localparam int OP_DEST_MSB = 6;
  localparam int OP_DEST_LSB = 4;
  localparam int OP_BIT3     = 3;
  localparam int OP_SRC_MSB  = 2;
  localparam int OP_SRC_LSB  = 0;

  localparam logic [2:0] DEST_PC = 3'd7;
  localparam logic [2:0] SRC_ROM = 3'd1;

  function automatic logic [2:0] opDest(input logic [7:0] instr);
    return instr[OP_DEST_MSB:OP_DEST_LSB];
  endfunction

  function automatic logic [2:0] opSource(input logic [7:0] instr);
    return instr[OP_SRC_MSB:OP_SRC_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: async active-low reset, stall, parallel load and
// increment. Load has priority over increment; increment wraps modulo 2^WIDTH.
module pc_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetBar,
  input  logic             hold,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] loadValue,
  output logic [WIDTH-1:0] pc
);

  // Update the PC unless stalled; a load (jump) wins over a plain increment.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      pc <= RESET_VALUE;
    end else if (!hold) begin
      if (load) begin
        pc <= loadValue;
      end else if (inc) begin
        pc <= pc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// nic8 instruction sequencer: owns PC and IR, runs every instruction as a
// FETCH/EXEC pair and picks the next PC from the decoder's jump/skip signals.
// Optional jump-to-self halt detection is enabled by FETCH_HALT_DETECT_EN.
module fetch_unit
  import nic8_pkg::*;
#(
  parameter int WIDTH = NIC8_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             resetBar,
  input  logic             hold,
  input  logic [WIDTH-1:0] romData,
  input  logic [WIDTH-1:0] bus,
  input  logic             doJumpBar,
  input  logic             denyFetch,
  output logic [WIDTH-1:0] romAddr,
  output logic [WIDTH-1:0] ir,
  output logic             execPhase,
  output logic             halted
);

  fetchState_t      state;
  fetchState_t      stateNext;
  logic             pcLoad;
  logic             pcInc;
  logic             irLoad;
  logic             haltSet;
  logic [WIDTH-1:0] pc;

  pc_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_PC)
  ) pcReg (
    .clk       (clk),
    .resetBar  (resetBar),
    .hold      (hold),
    .load      (pcLoad),
    .inc       (pcInc),
    .loadValue (bus),
    .pc        (pc)
  );

  assign romAddr   = pc;
  assign execPhase = (state == ST_EXEC);

`ifdef FETCH_HALT_DETECT_EN
  logic [WIDTH-1:0] instrAddr;

  // Remember where the current instruction came from to spot jump-to-self.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      instrAddr <= RESET_PC;
    end else if (!hold && state == ST_FETCH) begin
      instrAddr <= pc;
    end
  end

  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      halted <= 1'b0;
    end else if (!hold && haltSet) begin
      halted <= 1'b1;
    end
  end
`else
  assign halted = 1'b0;
`endif

  // Next-state and PC/IR control; decoder inputs only matter in EXEC.
  always_comb begin
    stateNext = state;
    pcLoad    = 1'b0;
    pcInc     = 1'b0;
    irLoad    = 1'b0;
    haltSet   = 1'b0;
    case (state)
      ST_FETCH: begin
        irLoad    = 1'b1;
        pcInc     = 1'b1;
        stateNext = ST_EXEC;
      end
      ST_EXEC: begin
        stateNext = ST_FETCH;
        if (!doJumpBar) begin
          pcLoad = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
          if (bus == instrAddr) begin
            haltSet   = 1'b1;
            stateNext = ST_HALT;
          end
`endif
        end else if (denyFetch) begin
          pcInc = 1'b1;
        end
      end
      ST_HALT: begin
        stateNext = ST_HALT;
      end
      default: begin
        stateNext = ST_FETCH;
      end
    endcase
  end

  // Sequencer state register, frozen while stalled.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state <= ST_FETCH;
    end else if (!hold) begin
      state <= stateNext;
    end
  end

  // Instruction register, written only during FETCH.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      ir <= '0;
    end else if (!hold && irLoad) begin
      ir <= romData;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: ROM modelled as an array, decoder
// outputs driven directly; expected values are hand-computed per scenario.
module tb_fetch_unit;

  logic       clk;
  logic       resetBar;
  logic       hold;
  logic [7:0] romData;
  logic [7:0] bus;
  logic       doJumpBar;
  logic       denyFetch;
  logic [7:0] romAddr;
  logic [7:0] ir;
  logic       execPhase;
  logic       halted;

  logic [7:0] rom [256];

  int errors = 0;
  int checks = 0;

  fetch_unit #(
    .WIDTH    (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk       (clk),
    .resetBar  (resetBar),
    .hold      (hold),
    .romData   (romData),
    .bus       (bus),
    .doJumpBar (doJumpBar),
    .denyFetch (denyFetch),
    .romAddr   (romAddr),
    .ir        (ir),
    .execPhase (execPhase),
    .halted    (halted)
  );

  assign romData = rom[romAddr];

  // Free-running 10ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic jb, input logic df, input logic [7:0] b, input logic h);
    doJumpBar = jb;
    denyFetch = df;
    bus       = b;
    hold      = h;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    resetBar = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    @(negedge clk);
    resetBar = 1'b1;
  endtask

  task automatic checkState(input string name, input logic [7:0] expPc, input logic [7:0] expIr,
                            input logic expExec, input logic expHalt);
    checks++;
    if (romAddr !== expPc || ir !== expIr || execPhase !== expExec || halted !== expHalt) begin
      errors++;
      $display("[TB] FAIL %s actual pc=%h ir=%h exec=%b halt=%b required pc=%h ir=%h exec=%b halt=%b",
               name, romAddr, ir, execPhase, halted, expPc, expIr, expExec, expHalt);
    end
  endtask

  task automatic test_reset();
    resetBar = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkState("reset_state", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    resetBar = 1'b1;
  endtask

  task automatic test_immediate();
    rom[8'h00] = 8'h21;
    rom[8'h01] = 8'h55;
    doReset();
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
    nextEdge();
    checkState("imm_fetch", 8'h01, 8'h21, 1'b1, 1'b0);
    nextEdge();
    checkState("imm_skip", 8'h02, 8'h21, 1'b0, 1'b0);
  endtask

  task automatic test_fallthrough();
    rom[8'h00] = 8'h32;
    rom[8'h01] = 8'h33;
    doReset();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    nextEdge();
    checkState("fall_fetch", 8'h01, 8'h32, 1'b1, 1'b0);
    nextEdge();
    checkState("fall_exec", 8'h01, 8'h32, 1'b0, 1'b0);
    nextEdge();
    checkState("fall_next", 8'h02, 8'h33, 1'b1, 1'b0);
  endtask

  task automatic test_jump();
    rom[8'h00] = 8'h80;
    rom[8'h10] = 8'hC7;
    rom[8'h40] = 8'h5A;
    doReset();
    nextEdge();
    applyStimulus(1'b0, 1'b1, 8'h10, 1'b0);
    nextEdge();
    checkState("jump_to10", 8'h10, 8'h80, 1'b0, 1'b0);
    // Decoder values during FETCH must be ignored.
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b0);
    nextEdge();
    checkState("jump_fetch_ignores_dec", 8'h11, 8'hC7, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h40, 1'b0);
    nextEdge();
    checkState("jump_over_skip", 8'h40, 8'hC7, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    nextEdge();
    checkState("jump_target_fetch", 8'h41, 8'h5A, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    rom[8'h00] = 8'h80;
    rom[8'hFF] = 8'h21;
    doReset();
    nextEdge();
    applyStimulus(1'b0, 1'b0, 8'hFF, 1'b0);
    nextEdge();
    checkState("wrap_at_ff", 8'hFF, 8'h80, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
    nextEdge();
    checkState("wrap_fetch", 8'h00, 8'h21, 1'b1, 1'b0);
    nextEdge();
    checkState("wrap_skip", 8'h01, 8'h21, 1'b0, 1'b0);
  endtask

  task automatic test_hold();
    rom[8'h00] = 8'h21;
    rom[8'h01] = 8'h66;
    rom[8'h02] = 8'h32;
    doReset();
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
    nextEdge();
    checkState("hold_pre", 8'h01, 8'h21, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h99, 1'b1);
    for (int i = 0; i < 3; i++) begin
      nextEdge();
      checkState($sformatf("hold_stall%0d", i), 8'h01, 8'h21, 1'b1, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
    nextEdge();
    checkState("hold_release", 8'h02, 8'h21, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    nextEdge();
    checkState("hold_after", 8'h03, 8'h32, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_exec();
    rom[8'h00] = 8'h21;
    doReset();
    applyStimulus(1'b0, 1'b1, 8'h40, 1'b0);
    nextEdge();
    checkState("midexec_pre", 8'h01, 8'h21, 1'b1, 1'b0);
    #2;
    resetBar = 1'b0;
    #1;
    checkState("midexec_async", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    resetBar = 1'b1;
  endtask

  task automatic test_halt();
    rom[8'h00] = 8'h80;
    rom[8'h05] = 8'h87;
    doReset();
    nextEdge();
    applyStimulus(1'b0, 1'b0, 8'h05, 1'b0);
    nextEdge();
    checkState("halt_jump_to5", 8'h05, 8'h80, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    nextEdge();
    checkState("halt_fetch5", 8'h06, 8'h87, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h05, 1'b0);
    nextEdge();
`ifdef FETCH_HALT_DETECT_EN
    checkState("halt_enter", 8'h05, 8'h87, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      nextEdge();
      checkState($sformatf("halt_frozen%0d", i), 8'h05, 8'h87, 1'b0, 1'b1);
    end
    doReset();
    #1;
    checkState("halt_cleared", 8'h00, 8'h00, 1'b0, 1'b0);
`else
    checkState("loop_back0", 8'h05, 8'h87, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nextEdge();
      checkState($sformatf("loop_fetch%0d", i), 8'h06, 8'h87, 1'b1, 1'b0);
      nextEdge();
      checkState($sformatf("loop_back%0d", i + 1), 8'h05, 8'h87, 1'b0, 1'b0);
    end
`endif
  endtask

  // Run all scenarios in sequence, then report.
  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 8'h00;
    resetBar = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    test_reset();
    test_immediate();
    test_fallthrough();
    test_jump();
    test_wrap();
    test_hold();
    test_reset_mid_exec();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction sequencer for the nic8 datapath. It owns the program counter and instruction register, drives the ROM address, and presents `ir` to the instruction decoder.
- It consumes the decoder's `doJumpBar` and `denyFetch` outputs to choose the next PC: jump, skip an immediate ROM operand, or fall through.
- It is the producer end of the `ir` / jump-control interface. Every instruction runs as a two-phase FETCH/EXEC sequence.

Parameters:
- WIDTH, 8, width of PC, ROM address, ROM data, bus and IR.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetBar  input  1  asynchronous active-low reset.
- hold  input  1  stall; when 1, all state is frozen.
- romData  input  WIDTH  ROM byte at `romAddr` (combinational ROM).
- bus  input  WIDTH  datapath bus value during EXEC; this is the jump target.
- doJumpBar  input  1  from decoder; 0 = take jump this EXEC.
- denyFetch  input  1  from decoder; 1 = instruction consumes the ROM byte at PC (immediate) or jumps.
- romAddr  output  WIDTH  current PC.
- ir  output  WIDTH  instruction register, fed to the decoder.
- execPhase  output  1  0 = FETCH, 1 = EXEC. The decoder outputs are meaningful only when this is 1.
- halted  output  1  sticky halt flag (see Optional Feature).

Behaviour:
- Reset (async, resetBar=0), taking effect immediately regardless of phase:
  - pc=RESET_PC, ir=8'h00, state=FETCH, halted=0.
  - Reset mid-EXEC discards the instruction; no PC update occurs.
- `romAddr` = pc, combinationally.
- `execPhase` = (state==EXEC), registered state.
- States: FETCH, EXEC, and HALT (HALT exists only with the optional feature).
- FETCH, on edge with hold=0:
  - ir <= romData; pc <= pc+1; state <= EXEC.
- EXEC, on edge with hold=0, priority order:
  1. doJumpBar=0: pc <= bus. This also covers a jump whose target is a ROM immediate; `bus` then carries that byte, and the jump wins over the skip.
  2. else denyFetch=1: pc <= pc+1, skipping the consumed immediate.
  3. else: pc unchanged.
  - In all three cases: state <= FETCH.
- hold=1 in any state: pc, ir, state and halted are unchanged. `romAddr` and `ir` stay stable for the whole stall.
- Arithmetic: pc increments modulo 2^WIDTH (8'hFF+1 -> 8'h00). No carry out.
- ir is written only in FETCH. During FETCH it holds the previous instruction.
- Throughput: one instruction per 2 unstalled cycles.
- Latency: the opcode at address A is visible on `ir` one edge after a FETCH with pc=A.
- Decoder inputs are sampled only in EXEC. `doJumpBar` and `denyFetch` values during FETCH are ignored.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - An extra register `instrAddr` captures pc in FETCH.
  - In EXEC, if doJumpBar=0 and bus==instrAddr (jump-to-self), then halted <= 1, pc <= bus, state <= HALT.
  - HALT is absorbing until reset: no fetches, pc and ir frozen, `execPhase`=0.
- Undefined:
  - halted is tied 0; no `instrAddr` register and no HALT state.
  - A jump-to-self loops forever through FETCH/EXEC.

Decomposition:
- Shared package `nic8_pkg`:
  - WIDTH default.
  - State encoding constants: ST_FETCH=2'd0, ST_EXEC=2'd1, ST_HALT=2'd2.
  - Opcode field positions: dest=ir[6:4], source=ir[2:0], bit7, bit3.
  - Named constants: DEST_PC=3'd7, SRC_ROM=3'd1.
- Natural sub-module: `pc_reg`, a WIDTH-bit register with async active-low reset, hold, load and increment. The FSM stays in fetch_unit.

Test Plan:
1. Reset release, ROM[0]=8'h21 (load A from ROM; decoder gives denyFetch=1, doJumpBar=1), hold=0 -> ir=8'h21 after edge 1 with pc=1; pc=2 after edge 2; execPhase toggles 0,1,0.
2. Fall-through: ROM[0]=8'h32 (A->B), denyFetch=0, doJumpBar=1 -> pc goes 0->1->1, next FETCH reads ROM[1].
3. Jump: pc=8'h10, EXEC with doJumpBar=0, bus=8'h40, denyFetch=1 -> pc=8'h40, not 8'h12; next ir=ROM[8'h40].
4. Wrap: pc=8'hFF, FETCH -> pc=8'h00; EXEC with immediate skip -> pc=8'h01.
5. hold=1 for 3 cycles mid-EXEC, then release -> pc, ir and execPhase stay constant during the stall; behaviour afterwards is identical to the unstalled run.
6. FETCH_HALT_DETECT_EN: instruction at 8'h05 jumps with bus=8'h05 -> halted=1, pc=8'h05 frozen over 10 cycles; resetBar pulse -> halted=0, pc=RESET_PC. Without the macro: pc repeatedly 05->06->05, halted=0.
